// File: rtl/cpu_bus_responder_pkg.sv
// Shared definitions for the CPU bus responder: widths, region map, FSM states
// and bus-cycle types, plus the address-region decoder.
package cpu_bus_responder_pkg;

  localparam int unsigned REG_WIDTH  = 8;
  localparam int unsigned ADDR_WIDTH = 16;

  localparam logic [ADDR_WIDTH-1:0] RAM_END  = 16'h1FFF;
  localparam logic [ADDR_WIDTH-1:0] PER_BASE = 16'h2000;
  localparam logic [ADDR_WIDTH-1:0] PER_END  = 16'h3FFF;

  typedef enum logic {
    RSP_IDLE,
    RSP_PER_WAIT
  } rsp_state_e;

  // Encoded to match the CPU's r_w_n pin directly.
  typedef enum logic {
    BUS_WRITE = 1'b0,
    BUS_READ  = 1'b1
  } bus_cyc_e;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_PER,
    RGN_OPEN
  } region_e;

  function automatic region_e decode_region(input logic [ADDR_WIDTH-1:0] a);
    if (a <= RAM_END)                      return RGN_RAM;
    else if (a >= PER_BASE && a <= PER_END) return RGN_PER;
    else                                   return RGN_OPEN;
  endfunction

endpackage

// File: rtl/cpu_bus_responder_work_ram.sv
// Synchronous single-port work RAM, write-first on a simultaneous read/write.
module work_ram #(
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_o       <= wdata_i;
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/cpu_bus_responder.sv
// Target side of the CPU external bus: work RAM, peripheral req/ack window
// with timeout, and open-bus return for unmapped space.
module cpu_bus_responder
  import cpu_bus_responder_pkg::*;
#(
  parameter int unsigned RAM_DEPTH = 2048,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cyc,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  r_w_n,
  input  logic [REG_WIDTH-1:0]  wdata,
  output logic [REG_WIDTH-1:0]  rdata,
  output logic                  done,
  output logic                  rdy,
  output logic                  timeout,
  output logic                  per_req,
  output logic [2:0]            per_addr,
  output logic                  per_we,
  output logic [REG_WIDTH-1:0]  per_wdata,
  input  logic [REG_WIDTH-1:0]  per_rdata,
  input  logic                  per_ack
);

  localparam int unsigned RAM_AW = $clog2(RAM_DEPTH);
  localparam int unsigned CW     = $clog2(TIMEOUT);

  rsp_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [REG_WIDTH-1:0] rdata_q, rdata_d;
  logic [REG_WIDTH-1:0] latch_q, latch_d;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;
  logic                 per_req_q, per_req_d;
  logic [2:0]           per_addr_q, per_addr_d;
  logic                 per_we_q, per_we_d;
  logic [REG_WIDTH-1:0] per_wdata_q, per_wdata_d;
  logic                 ram_rd_q, ram_rd_d;

  region_e              rgn;
  logic                 is_read;
  logic                 accept;
  logic                 ram_en;
  logic [REG_WIDTH-1:0] ram_q;
  logic [REG_WIDTH-1:0] obus;

  assign rgn     = decode_region(addr);
  assign is_read = (bus_cyc_e'(r_w_n) == BUS_READ);
  assign accept  = cyc && (state_q == RSP_IDLE);
  assign ram_en  = accept && (rgn == RGN_RAM);

  work_ram #(
    .DEPTH(RAM_DEPTH),
    .WIDTH(REG_WIDTH)
  ) u_work_ram (
    .clk_i  (clk),
    .en_i   (ram_en),
    .we_i   (!is_read),
    .addr_i (addr[RAM_AW-1:0]),
    .wdata_i(wdata),
    .rdata_o(ram_q)
  );

  // RAM read data lands one cycle late, so the open-bus value bypasses the
  // latch while that data is still only on the RAM output.
  assign obus = ram_rd_q ? ram_q : latch_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rdata_d     = ram_rd_q ? ram_q : rdata_q;
    latch_d     = obus;
    done_d      = 1'b0;
    tmo_d       = 1'b0;
    per_req_d   = per_req_q;
    per_addr_d  = per_addr_q;
    per_we_d    = per_we_q;
    per_wdata_d = per_wdata_q;
    ram_rd_d    = 1'b0;
    case (state_q)
      RSP_IDLE: begin
        if (accept) begin
          if (!is_read) latch_d = wdata;
          case (rgn)
            RGN_RAM: begin
              done_d   = 1'b1;
              ram_rd_d = is_read;
            end
            RGN_OPEN: begin
              done_d = 1'b1;
              if (is_read) rdata_d = obus;
            end
            default: begin
              per_req_d   = 1'b1;
              per_addr_d  = addr[2:0];
              per_we_d    = !is_read;
              per_wdata_d = wdata;
              cnt_d       = '0;
              state_d     = RSP_PER_WAIT;
            end
          endcase
        end
      end
      RSP_PER_WAIT: begin
        if (per_ack) begin
          per_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = RSP_IDLE;
          if (!per_we_q) begin
            rdata_d = per_rdata;
            latch_d = per_rdata;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          per_req_d = 1'b0;
          done_d    = 1'b1;
          tmo_d     = 1'b1;
          state_d   = RSP_IDLE;
          if (!per_we_q) rdata_d = latch_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RSP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RSP_IDLE;
      cnt_q       <= '0;
      rdata_q     <= '0;
      latch_q     <= '0;
      done_q      <= 1'b0;
      tmo_q       <= 1'b0;
      per_req_q   <= 1'b0;
      per_addr_q  <= '0;
      per_we_q    <= 1'b0;
      per_wdata_q <= '0;
      ram_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      latch_q     <= latch_d;
      done_q      <= done_d;
      tmo_q       <= tmo_d;
      per_req_q   <= per_req_d;
      per_addr_q  <= per_addr_d;
      per_we_q    <= per_we_d;
      per_wdata_q <= per_wdata_d;
      ram_rd_q    <= ram_rd_d;
    end
  end

  assign rdata     = ram_rd_q ? ram_q : rdata_q;
  assign done      = done_q;
  assign rdy       = (state_q == RSP_IDLE);
  assign timeout   = tmo_q;
  assign per_req   = per_req_q;
  assign per_addr  = per_addr_q;
  assign per_we    = per_we_q;
  assign per_wdata = per_wdata_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: RAM, open bus, peripheral ack/timeout,
// protocol violations and asynchronous reset.
module tb_cpu_bus_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cyc;
  logic [15:0] addr;
  logic        r_w_n;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        done;
  logic        rdy;
  logic        timeout;
  logic        per_req;
  logic [2:0]  per_addr;
  logic        per_we;
  logic [7:0]  per_wdata;
  logic [7:0]  per_rdata;
  logic        per_ack;

  int total = 0;
  int bad   = 0;
  int cnt;

  always #5 clk = ~clk;

  cpu_bus_responder #(
    .RAM_DEPTH(2048),
    .TIMEOUT  (16)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cyc      (cyc),
    .addr     (addr),
    .r_w_n    (r_w_n),
    .wdata    (wdata),
    .rdata    (rdata),
    .done     (done),
    .rdy      (rdy),
    .timeout  (timeout),
    .per_req  (per_req),
    .per_addr (per_addr),
    .per_we   (per_we),
    .per_wdata(per_wdata),
    .per_rdata(per_rdata),
    .per_ack  (per_ack)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [15:0] a, input logic rd, input logic [7:0] d);
    cyc   = 1'b1;
    addr  = a;
    r_w_n = rd;
    wdata = d;
  endtask

  task automatic idle_bus();
    cyc   = 1'b0;
    addr  = 16'h0000;
    r_w_n = 1'b1;
    wdata = 8'h00;
  endtask

  initial begin
    reset_n   = 1'b0;
    per_ack   = 1'b0;
    per_rdata = 8'h00;
    idle_bus();
    step();
    step();
    chk("rst_rdata", 16'(rdata), 16'h00);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_rdy", 16'(rdy), 16'h1);
    chk("rst_timeout", 16'(timeout), 16'h0);
    chk("rst_per_req", 16'(per_req), 16'h0);
    chk("rst_per_fields", {5'd0, per_addr, per_we, per_wdata}, 16'h0000);
    reset_n = 1'b1;
    step();

    // 1: RAM write then mirrored read-after-write, back to back.
    bus(16'h0005, 1'b0, 8'h5A);
    step();
    chk("t1_wr_done", 16'(done), 16'h1);
    chk("t1_wr_rdy", 16'(rdy), 16'h1);
    bus(16'h0805, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t1_rd_done", 16'(done), 16'h1);
    chk("t1_rd_rdata", 16'(rdata), 16'h5A);
    chk("t1_rd_rdy", 16'(rdy), 16'h1);
    step();
    chk("t1_done_drop", 16'(done), 16'h0);

    // 4: open bus returns last RAM read data (write to $4000 seeds $77 first).
    bus(16'h0010, 1'b0, 8'h33);
    step();
    bus(16'h4000, 1'b0, 8'h77);
    step();
    chk("t4_unmapped_wr_done", 16'(done), 16'h1);
    bus(16'h0010, 1'b1, 8'h00);
    step();
    chk("t4_ram_rdata", 16'(rdata), 16'h33);
    bus(16'hC000, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t4_obus_done", 16'(done), 16'h1);
    chk("t4_obus_rdata", 16'(rdata), 16'h33);
    step();

    // 2: peripheral read, ack 3 cycles after per_req rises.
    bus(16'h2002, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t2_per_req", 16'(per_req), 16'h1);
    chk("t2_per_addr", 16'(per_addr), 16'h2);
    chk("t2_per_we", 16'(per_we), 16'h0);
    cnt = 0;
    for (int i = 1; i <= 4; i++) begin
      if (rdy == 1'b0) cnt++;
      chk("t2_no_early_done", 16'(done), 16'h0);
      if (i == 4) begin
        per_ack   = 1'b1;
        per_rdata = 8'h80;
      end else begin
        step();
      end
    end
    step();
    per_ack = 1'b0;
    chk("t2_rdy_low_cycles", 16'(cnt), 16'd4);
    chk("t2_done", 16'(done), 16'h1);
    chk("t2_rdata", 16'(rdata), 16'h80);
    chk("t2_per_req_drop", 16'(per_req), 16'h0);
    chk("t2_rdy_back", 16'(rdy), 16'h1);
    chk("t2_no_timeout", 16'(timeout), 16'h0);
    step();

    // 3: peripheral write with no ack times out at cycle 17.
    bus(16'h3FF9, 1'b0, 8'h1F);
    step();
    idle_bus();
    chk("t3_per_addr", 16'(per_addr), 16'h1);
    chk("t3_per_we", 16'(per_we), 16'h1);
    chk("t3_per_wdata", 16'(per_wdata), 16'h1F);
    cnt = 0;
    for (int i = 2; i <= 16; i++) begin
      step();
      if (done || timeout || !per_req) cnt++;
    end
    chk("t3_held_until_16", 16'(cnt), 16'd0);
    step();
    chk("t3_done17", 16'(done), 16'h1);
    chk("t3_timeout17", 16'(timeout), 16'h1);
    chk("t3_per_req_drop", 16'(per_req), 16'h0);
    chk("t3_rdy", 16'(rdy), 16'h1);
    step();
    chk("t3_timeout_pulse", 16'(timeout), 16'h0);
    bus(16'h5000, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t3_obus_done", 16'(done), 16'h1);
    chk("t3_obus_rdata", 16'(rdata), 16'h1F);

    // Timed-out peripheral read returns open bus.
    bus(16'h2000, 1'b1, 8'h00);
    step();
    idle_bus();
    for (int i = 2; i <= 17; i++) step();
    chk("t3b_tmo_read_timeout", 16'(timeout), 16'h1);
    chk("t3b_tmo_read_rdata", 16'(rdata), 16'h1F);
    step();

    // 5: cyc during PER_WAIT ignored; per_ack in IDLE ignored.
    bus(16'h2003, 1'b1, 8'h00);
    step();
    idle_bus();
    step();
    bus(16'h0005, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t5_viol_no_done", 16'(done), 16'h0);
    chk("t5_viol_per_req", 16'(per_req), 16'h1);
    chk("t5_viol_per_addr", 16'(per_addr), 16'h3);
    per_ack   = 1'b1;
    per_rdata = 8'hC3;
    step();
    per_ack = 1'b0;
    chk("t5_ack_done", 16'(done), 16'h1);
    chk("t5_ack_rdata", 16'(rdata), 16'hC3);
    step();
    chk("t5_single_done", 16'(done), 16'h0);
    per_ack   = 1'b1;
    per_rdata = 8'hEE;
    step();
    per_ack = 1'b0;
    chk("t5_idle_ack_done", 16'(done), 16'h0);
    chk("t5_idle_ack_per_req", 16'(per_req), 16'h0);
    chk("t5_idle_ack_rdy", 16'(rdy), 16'h1);
    bus(16'hC000, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t5_latch_kept", 16'(rdata), 16'hC3);
    step();

    // 6: asynchronous reset in PER_WAIT, stale ack afterwards, RAM retained.
    bus(16'h2004, 1'b1, 8'h00);
    step();
    idle_bus();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_async_per_req", 16'(per_req), 16'h0);
    chk("t6_async_rdy", 16'(rdy), 16'h1);
    chk("t6_async_rdata", 16'(rdata), 16'h00);
    chk("t6_async_fields", {5'd0, per_addr, per_we, per_wdata}, 16'h0000);
    step();
    reset_n   = 1'b1;
    per_ack   = 1'b1;
    per_rdata = 8'h99;
    step();
    per_ack = 1'b0;
    chk("t6_late_ack_done", 16'(done), 16'h0);
    chk("t6_late_ack_per_req", 16'(per_req), 16'h0);
    bus(16'h0005, 1'b1, 8'h00);
    step();
    idle_bus();
    chk("t6_ram_done", 16'(done), 16'h1);
    chk("t6_ram_kept", 16'(rdata), 16'h5A);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
